gol_generation_sequencer: RTL and testbench

//   Runs N Game-of-Life generations back to back on the GameOfLifeWrapper engine, with no HPS involvement between generations.

---
 rtl/gol_generation_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_gol_generation_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_generation_sequencer.sv
// Runs N Game-of-Life generations on the engine, ping-ponging between board buffers A and B.
// Engine handshake: enable is held high with both addresses stable until completed rises, then dropped until completed falls.
module gol_generation_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_abort,
  input  logic [ADDR_W-1:0] io_buf_a_address,
  input  logic [ADDR_W-1:0] io_buf_b_address,
  input  logic [GEN_W-1:0]  io_generations,
  output logic              io_engine_enable,
  output logic [ADDR_W-1:0] io_engine_starting_address,
  output logic [ADDR_W-1:0] io_engine_result_address,
  input  logic              io_engine_completed,
  output logic              io_busy,
  output logic              io_done,
  output logic [1:0]        io_error,
  output logic [ADDR_W-1:0] io_final_address,
  output logic [GEN_W-1:0]  io_generation_count
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic              start_q;
  logic              rise_q;
  logic [GEN_W-1:0]  n_q;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [TMR_W-1:0]  timer;
  logic              enable;
  logic [ADDR_W-1:0] starting;
  logic [ADDR_W-1:0] result;
  logic              busy;
  logic              done;
  logic [1:0]        error;
  logic [ADDR_W-1:0] final_addr;
  logic [GEN_W-1:0]  count;
  logic              idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      start_q    <= 1'b1;
      rise_q     <= 1'b0;
      n_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      src        <= '0;
      dst        <= '0;
      timer      <= '0;
      enable     <= 1'b0;
      starting   <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 2'b00;
      final_addr <= '0;
      count      <= '0;
    end else begin
      start_q <= io_start;
      // Rises seen while a run is in flight are dropped, not deferred.
      rise_q  <= io_start & ~start_q & idle_like;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rise_q) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 2'b00;
            count      <= '0;
            n_q        <= io_generations;
            a_q        <= io_buf_a_address;
            b_q        <= io_buf_b_address;
            src        <= io_buf_a_address;
            dst        <= io_buf_b_address;
            final_addr <= io_buf_a_address;
          end
        end
        S_LOAD: begin
          if (io_abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (a_q == b_q) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 2'b10;
          end else if (n_q == '0) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            final_addr <= a_q;
            count      <= '0;
          end else begin
            state    <= S_RUN;
            enable   <= 1'b1;
            starting <= src;
            result   <= dst;
            timer    <= '0;
          end
        end
        S_RUN: begin
          if (io_abort) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            enable <= 1'b0;
          end else if (io_engine_completed) begin
            state      <= S_DRAIN;
            count      <= count + GEN_W'(1);
            final_addr <= dst;
            src        <= dst;
            dst        <= src;
            enable     <= 1'b0;
            timer      <= '0;
          end else if (timer == TMR_LAST) begin
            state  <= S_ERROR;
            busy   <= 1'b0;
            error  <= 2'b01;
            enable <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_DRAIN: begin
          if (io_abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (!io_engine_completed) begin
            if (count == n_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_RUN;
              enable   <= 1'b1;
              starting <= src;
              result   <= dst;
              timer    <= '0;
            end
          end else if (timer == TMR_LAST) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            error <= 2'b01;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          enable <= 1'b0;
        end
      endcase
    end
  end

  assign io_engine_enable           = enable;
  assign io_engine_starting_address = starting;
  assign io_engine_result_address   = result;
  assign io_busy                    = busy;
  assign io_done                    = done;
  assign io_error                   = error;
  assign io_final_address           = final_addr;
  assign io_generation_count        = count;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Bench for gol_generation_sequencer: behavioural engine, table of runs, and hand-written abort/timeout/reset sequences.
module tb_gol_generation_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic        io_abort;
  logic [11:0] io_buf_a_address;
  logic [11:0] io_buf_b_address;
  logic [15:0] io_generations;
  logic        io_engine_enable;
  logic [11:0] io_engine_starting_address;
  logic [11:0] io_engine_result_address;
  logic        io_engine_completed = 1'b0;
  logic        io_busy;
  logic        io_done;
  logic [1:0]  io_error;
  logic [11:0] io_final_address;
  logic [15:0] io_generation_count;

  gol_generation_sequencer #(
    .ADDR_W(12), .GEN_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .io_start                   (io_start),
    .io_abort                   (io_abort),
    .io_buf_a_address           (io_buf_a_address),
    .io_buf_b_address           (io_buf_b_address),
    .io_generations             (io_generations),
    .io_engine_enable           (io_engine_enable),
    .io_engine_starting_address (io_engine_starting_address),
    .io_engine_result_address   (io_engine_result_address),
    .io_engine_completed        (io_engine_completed),
    .io_busy                    (io_busy),
    .io_done                    (io_done),
    .io_error                   (io_error),
    .io_final_address           (io_final_address),
    .io_generation_count        (io_generation_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic        engine_stuck = 1'b0;
  int          comp_rises   = 0;
  int          en_rises     = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] n;
    logic        exp_done;
    logic [1:0]  exp_error;
    logic [15:0] exp_count;
    logic [11:0] exp_final;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Engine model: completes 5 cycles after enable, holds completed until enable drops.
  int          eng_cyc = 0;
  logic        prev_en = 1'b0;
  logic [23:0] held_addr = '0;
  always @(posedge clock) begin
    #1;
    if (io_engine_enable) begin
      if (!prev_en) begin
        en_rises++;
        held_addr = {io_engine_starting_address, io_engine_result_address};
        if (exp_q.size() == 0) begin
          check("unexpected_enable", 32'(en_rises), 32'(0));
        end else begin
          check("engine_addresses", 32'(held_addr), 32'(exp_q.pop_front()));
        end
      end else if ({io_engine_starting_address, io_engine_result_address} != held_addr) begin
        check("address_stability", 32'({io_engine_starting_address, io_engine_result_address}),
              32'(held_addr));
      end
      eng_cyc++;
      if (eng_cyc >= 5 && !engine_stuck) begin
        if (!io_engine_completed) comp_rises++;
        io_engine_completed = 1'b1;
      end
    end else begin
      eng_cyc = 0;
      io_engine_completed = 1'b0;
    end
    prev_en = io_engine_enable;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Returns just after the edge that first samples io_start high (edge k).
  task automatic launch(input logic [11:0] a, input logic [11:0] b, input logic [15:0] n);
    tick();
    io_buf_a_address = a;
    io_buf_b_address = b;
    io_generations   = n;
    io_start         = 1'b0;
    tick();
    io_start = 1'b1;
    tick();
  endtask

  task automatic push_gens(input logic [11:0] a, input logic [11:0] b, input int n);
    for (int g = 0; g < n; g++) begin
      if (g % 2 == 0) exp_q.push_back({a, b});
      else            exp_q.push_back({b, a});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (io_busy && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(n < 300), 32'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int rises0;
    rises0 = en_rises;
    if (v.exp_error == 2'b00) push_gens(v.a, v.b, int'(v.n));
    launch(v.a, v.b, v.n);
    tick();
    check("load_busy", 32'(io_busy), 32'(1));
    check("load_enable", 32'(io_engine_enable), 32'(0));
    check("load_clears", 32'({io_done, io_error, io_generation_count}), 32'(0));
    tick();
    if (v.exp_error == 2'b10) begin
      check("cfg_error_k2", 32'({io_busy, io_error}), 32'(3'b010));
    end else if (v.n == 16'd0) begin
      check("zero_n_done_k2", 32'({io_busy, io_done}), 32'(2'b01));
    end else begin
      check("enable_k2", 32'(io_engine_enable), 32'(1));
    end
    wait_idle("run_idle_timeout");
    check("run_done", 32'(io_done), 32'(v.exp_done));
    check("run_error", 32'(io_error), 32'(v.exp_error));
    check("run_count", 32'(io_generation_count), 32'(v.exp_count));
    check("run_final", 32'(io_final_address), 32'(v.exp_final));
    check("run_enable_low", 32'(io_engine_enable), 32'(0));
    check("run_gen_enables", 32'(en_rises - rises0), 32'(v.exp_error == 2'b00 ? int'(v.n) : 0));
    check("run_queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int base;
    int n;
    vecs[0] = '{12'h000, 12'h100, 16'd3, 1'b1, 2'b00, 16'd3, 12'h100};
    vecs[1] = '{12'h000, 12'h100, 16'd0, 1'b1, 2'b00, 16'd0, 12'h000};
    vecs[2] = '{12'h040, 12'h040, 16'd2, 1'b0, 2'b10, 16'd0, 12'h040};
    vecs[3] = '{12'h200, 12'h300, 16'd2, 1'b1, 2'b00, 16'd2, 12'h200};
    vecs[4] = '{12'h010, 12'h020, 16'd1, 1'b1, 2'b00, 16'd1, 12'h020};
    vecs[5] = '{12'h123, 12'h456, 16'd4, 1'b1, 2'b00, 16'd4, 12'h123};

    reset = 1'b1;
    io_start = 1'b0;
    io_abort = 1'b0;
    io_buf_a_address = '0;
    io_buf_b_address = '0;
    io_generations = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", 32'({io_engine_enable, io_busy, io_done, io_error, io_generation_count}), 32'(0));
    check("reset_addresses", 32'({io_engine_starting_address, io_engine_result_address, io_final_address}), 32'(0));

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout: engine never completes, TIMEOUT_CYCLES=16.
    engine_stuck = 1'b1;
    exp_q.push_back({12'h000, 12'h100});
    launch(12'h000, 12'h100, 16'd2);
    tick();
    tick();
    check("to_run_entry", 32'(io_engine_enable), 32'(1));
    repeat (15) tick();
    check("to_still_running", 32'({io_busy, io_engine_enable, io_error}), 32'(4'b1100));
    tick();
    check("to_error", 32'({io_busy, io_engine_enable, io_done, io_error}), 32'(5'b00001));
    check("to_count", 32'(io_generation_count), 32'(0));
    engine_stuck = 1'b0;
    tick();
    run_vec('{12'h000, 12'h100, 16'd1, 1'b1, 2'b00, 16'd1, 12'h100});

    // Abort coinciding with the 2nd completed, plus a simultaneous start rise.
    push_gens(12'h000, 12'h100, 2);
    launch(12'h000, 12'h100, 16'd4);
    io_start = 1'b0;
    base = comp_rises;
    n = 0;
    while (comp_rises != base + 2 && n < 200) begin
      tick();
      n++;
    end
    check("abort_wait_timeout", 32'(n < 200), 32'(1));
    io_abort = 1'b1;
    io_start = 1'b1;
    tick();
    io_abort = 1'b0;
    check("abort_idle", 32'({io_busy, io_engine_enable, io_done, io_error}), 32'(0));
    check("abort_count", 32'(io_generation_count), 32'(1));
    check("abort_final", 32'(io_final_address), 32'(12'h100));
    repeat (3) tick();
    check("abort_no_relaunch", 32'({io_busy, io_engine_enable}), 32'(0));
    check("abort_queue_empty", 32'(exp_q.size()), 32'(0));
    io_start = 1'b0;

    // Start held high through reset must not launch.
    io_start = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("reset_start_held", 32'({io_busy, io_engine_enable, io_done}), 32'(0));
    run_vec(vecs[3]);

    // Reset in the middle of RUN.
    push_gens(12'h000, 12'h100, 3);
    launch(12'h000, 12'h100, 16'd3);
    tick();
    tick();
    check("midrst_enable", 32'(io_engine_enable), 32'(1));
    tick();
    reset = 1'b1;
    tick();
    check("midrst_outputs", 32'({io_engine_enable, io_busy, io_done, io_error, io_generation_count}), 32'(0));
    check("midrst_addresses", 32'({io_engine_starting_address, io_engine_result_address, io_final_address}), 32'(0));
    reset = 1'b0;
    exp_q.delete();
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
